// File: rtl/demux1to2_buf_pkg.sv
// Shared constants and payload types for the 1:2 buffered stream demultiplexer.
package demux1to2_buf_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Source beat as seen on the input side: destination select plus word.
  typedef struct packed {
    logic              sel;
    logic [DATA_W-1:0] data;
  } in_beat_t;

endpackage

// File: rtl/demux1to2_buf_if.sv
// Stream bundle for demux1to2_buf: one source stream in, two destination streams out.
interface demux1to2_buf_if #(
  parameter int unsigned DATA_W = demux1to2_buf_pkg::DATA_W,
  parameter int unsigned CNT_W  = 2
);

  logic              in_valid;
  logic              in_sel;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              o0_valid;
  logic [DATA_W-1:0] o0_data;
  logic              o0_ready;
  logic [CNT_W-1:0]  o0_count;

  logic              o1_valid;
  logic [DATA_W-1:0] o1_data;
  logic              o1_ready;
  logic [CNT_W-1:0]  o1_count;

  // Producer plus both consumers.
  modport master (
    output in_valid, in_sel, in_data, o0_ready, o1_ready,
    input  in_ready, o0_valid, o0_data, o0_count, o1_valid, o1_data, o1_count
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_sel, in_data, o0_ready, o1_ready,
    output in_ready, o0_valid, o0_data, o0_count, o1_valid, o1_data, o1_count
  );

endinterface

// File: rtl/demux1to2_buf_sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and combinational head read.
module sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok_c;
  logic              pop_ok_c;
  logic [CNT_W-1:0]  count_nxt_c;

  // Pushes into a full FIFO and pops from an empty one are ignored.
  always_comb begin
    push_ok_c   = push && !full;
    pop_ok_c    = pop && !empty;
    count_nxt_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  // Storage is cleared on reset so the head reads zero while flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_ok_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

  a_count_max : assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));
  a_head_stable : assert property (@(posedge clk) disable iff (rst)
    (!empty && !pop) |=> (head_data == $past(head_data)));

endmodule

// File: rtl/demux1to2_buf.sv
// Routes one valid/ready source stream to one of two buffered destination streams.
module demux1to2_buf
  import demux1to2_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  demux1to2_buf_if.slave  bus
);

  if ((CNT_W != $clog2(DEPTH) + 1) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
    $error("demux1to2_buf: DEPTH must be a power of two >= 2 and CNT_W = log2(DEPTH)+1");
  end

  in_beat_t          beat_c;
  logic              in_ready_c;
  logic              push0_c;
  logic              push1_c;
  logic              pop0_c;
  logic              pop1_c;
  logic              full0;
  logic              full1;
  logic              empty0;
  logic              empty1;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;
  logic [DATA_W-1:0] head0;
  logic [DATA_W-1:0] head1;

  // Ready depends only on the selected FIFO's registered full flag; no pop-to-push bypass.
  always_comb begin
    beat_c     = '{sel: bus.in_sel, data: bus.in_data};
    in_ready_c = !rst && ((beat_c.sel == PORT1) ? !full1 : !full0);
    push0_c    = bus.in_valid && in_ready_c && (beat_c.sel == PORT0);
    push1_c    = bus.in_valid && in_ready_c && (beat_c.sel == PORT1);
    pop0_c     = bus.o0_ready && !empty0;
    pop1_c     = bus.o1_ready && !empty1;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0_c),
    .push_data (beat_c.data),
    .pop       (pop0_c),
    .head_data (head0),
    .count     (count0),
    .full      (full0),
    .empty     (empty0)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1_c),
    .push_data (beat_c.data),
    .pop       (pop1_c),
    .head_data (head1),
    .count     (count1),
    .full      (full1),
    .empty     (empty1)
  );

  assign bus.in_ready = in_ready_c;
  assign bus.o0_valid = !empty0;
  assign bus.o0_data  = head0;
  assign bus.o0_count = count0;
  assign bus.o1_valid = !empty1;
  assign bus.o1_data  = head1;
  assign bus.o1_count = count1;

endmodule

// File: tb/tb_demux1to2_buf.sv
// Scoreboard bench for demux1to2_buf: directed stimulus, negedge output monitor.
module tb_demux1to2_buf;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  demux1to2_buf_if #(.DATA_W(32), .CNT_W(2)) bus ();

  demux1to2_buf #(.DEPTH(2), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Output monitor: a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.o0_valid && bus.o0_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL o0_extra: got 0x%08h expected no word", bus.o0_data);
      end else begin
        chk("o0_data", bus.o0_data, q0.pop_front());
      end
    end
    if (!rst && bus.o1_valid && bus.o1_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL o1_extra: got 0x%08h expected no word", bus.o1_data);
      end else begin
        chk("o1_data", bus.o1_data, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sel, input logic [31:0] d, output int waited);
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
        tick();
        bus.in_valid = 1'b0;
        return;
      end
      waited++;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got no in_ready for 0x%08h expected acceptance", d);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus.o0_ready = 1'b1;
    bus.o1_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    chk("drain_q0_left", 32'(q0.size()), 32'd0);
    chk("drain_q1_left", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int w;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.in_data  = '0;
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_o0_valid", 32'(bus.o0_valid), 32'd0);
    chk("rst_o1_valid", 32'(bus.o1_valid), 32'd0);
    chk("rst_o0_count", 32'(bus.o0_count), 32'd0);
    chk("rst_o1_count", 32'(bus.o1_count), 32'd0);
    chk("rst_o0_data", bus.o0_data, 32'h0);
    chk("rst_o1_data", bus.o1_data, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Routing and one-cycle latency
    bus.o0_ready = 1'b1;
    bus.o1_ready = 1'b1;
    send(1'b0, 32'hAAAA0000, w);
    chk("route_o0_valid", 32'(bus.o0_valid), 32'd1);
    chk("route_o0_head", bus.o0_data, 32'hAAAA0000);
    chk("route_o1_idle", 32'(bus.o1_valid), 32'd0);
    send(1'b1, 32'hBBBB0001, w);
    chk("route_o1_valid", 32'(bus.o1_valid), 32'd1);
    chk("route_o1_head", bus.o1_data, 32'hBBBB0001);
    chk("route_o0_count0", 32'(bus.o0_count), 32'd0);
    tick();
    chk("route_o1_count0", 32'(bus.o1_count), 32'd0);

    // Full / backpressure
    bus.o0_ready = 1'b0;
    send(1'b0, 32'h1, w);
    send(1'b0, 32'h2, w);
    chk("bp_count_full", 32'(bus.o0_count), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 32'h3;
    @(negedge clk);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    tick();
    bus.o0_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_full_pop", 32'(bus.in_ready), 32'd0);
    tick();
    bus.o0_ready = 1'b0;
    chk("bp_count_after_pop", 32'(bus.o0_count), 32'd1);
    @(negedge clk);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    q0.push_back(32'h3);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_count_refill", 32'(bus.o0_count), 32'd2);
    drain(20);

    // Isolation: port 0 full and stalled, port 1 still flows
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b1;
    send(1'b0, 32'h21, w);
    send(1'b0, 32'h22, w);
    send(1'b1, 32'hCAFEF00D, w);
    chk("iso_no_wait", 32'(w), 32'd0);
    chk("iso_o1_valid", 32'(bus.o1_valid), 32'd1);
    chk("iso_o1_head", bus.o1_data, 32'hCAFEF00D);
    chk("iso_o0_count", 32'(bus.o0_count), 32'd2);
    tick();
    chk("iso_o0_count_hold", 32'(bus.o0_count), 32'd2);
    chk("iso_o1_count", 32'(bus.o1_count), 32'd0);
    drain(20);

    // Simultaneous push/pop with pointer wrap
    bus.o1_ready = 1'b0;
    send(1'b1, 32'h0F, w);
    chk("wrap_prefill", 32'(bus.o1_count), 32'd1);
    bus.o1_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 32'h10 + 32'(i);
      @(negedge clk);
      chk("wrap_in_ready", 32'(bus.in_ready), 32'd1);
      chk("wrap_o1_count", 32'(bus.o1_count), 32'd1);
      q1.push_back(bus.in_data);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("wrap_count_end", 32'(bus.o1_count), 32'd1);
    drain(20);
    chk("wrap_count_drained", 32'(bus.o1_count), 32'd0);

    // Pop request on an empty FIFO is ignored
    bus.o0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("empty_o0_valid", 32'(bus.o0_valid), 32'd0);
      chk("empty_o0_count", 32'(bus.o0_count), 32'd0);
      tick();
    end
    send(1'b0, 32'h5A5A5A5A, w);
    chk("empty_then_valid", 32'(bus.o0_valid), 32'd1);
    chk("empty_then_head", bus.o0_data, 32'h5A5A5A5A);
    drain(20);

    // Reset mid-stream flushes buffered words
    bus.o0_ready = 1'b0;
    send(1'b0, 32'h31, w);
    send(1'b0, 32'h32, w);
    chk("mid_count_pre", 32'(bus.o0_count), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 32'h33;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_o0_valid", 32'(bus.o0_valid), 32'd0);
    chk("mid_rst_o0_count", 32'(bus.o0_count), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_o0_data", bus.o0_data, 32'h0);
    q0.delete();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    send(1'b0, 32'h11111111, w);
    chk("mid_new_valid", 32'(bus.o0_valid), 32'd1);
    chk("mid_new_head", bus.o0_data, 32'h11111111);
    chk("mid_new_count", 32'(bus.o0_count), 32'd1);
    drain(20);
    chk("mid_final_count", 32'(bus.o0_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
